// File: rtl/door_sequencer.sv
// Entrance-door motor sequencer: merges open requests, drives open/close motor from limit switches.
// Optional motion-timeout fault guarded by `MOTION_TIMEOUT_EN.
module door_sequencer #(
  parameter int HOLD_CYCLES = 100,
  parameter int CNT_W       = 16,
  parameter int MOTION_MAX  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mat_out,
  input  logic       mat_in,
  input  logic       push_btn,
  input  logic       obstruct,
  input  logic       lim_open,
  input  logic       lim_closed,
  output logic       motor_open,
  output logic       motor_close,
  output logic       door_open,
  output logic [2:0] state,
  output logic [7:0] rev_cnt,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_CLOSED  = 3'd0,
    S_OPENING = 3'd1,
    S_OPEN    = 3'd2,
    S_CLOSING = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_hold;
  logic [CNT_W-1:0] w_hold_nxt;
  logic             r_btn_d1;
  logic             w_req;
  logic             w_reverse;
  logic             w_timeout;

`ifdef MOTION_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
  logic [CNT_W-1:0] r_motion;
  assign w_timeout = (r_motion == CNT_W'(MOTION_MAX - 1));
`else
  localparam bit TIMEOUT_EN = 1'b0;
  assign w_timeout = 1'b0;
`endif

  assign w_req     = mat_out | mat_in | (push_btn & ~r_btn_d1);
  assign w_reverse = obstruct | w_req;
  assign state     = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    case (r_state)
      S_CLOSED: begin
        if (w_req)            w_state_nxt = S_OPENING;
        else if (!lim_closed) w_state_nxt = S_CLOSING;
      end
      S_OPENING: begin
        if (lim_open) begin
          w_state_nxt = S_OPEN;
          w_hold_nxt  = HOLD_LOAD;
        end else if (w_timeout) begin
          w_state_nxt = S_FAULT;
        end
      end
      S_OPEN: begin
        if (w_req || obstruct)  w_hold_nxt  = HOLD_LOAD;
        else if (r_hold == '0)  w_state_nxt = S_CLOSING;
        else                    w_hold_nxt  = r_hold - CNT_W'(1);
      end
      S_CLOSING: begin
        // reversal outranks lim_closed seen in the same cycle
        if (w_reverse)       w_state_nxt = S_OPENING;
        else if (lim_closed) w_state_nxt = S_CLOSED;
        else if (w_timeout)  w_state_nxt = S_FAULT;
      end
      S_FAULT:  w_state_nxt = TIMEOUT_EN ? S_FAULT : S_CLOSED;
      default:  w_state_nxt = S_CLOSED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_CLOSED;
      r_hold      <= '0;
      r_btn_d1    <= 1'b0;
      motor_open  <= 1'b0;
      motor_close <= 1'b0;
      door_open   <= 1'b0;
      fault       <= 1'b0;
      rev_cnt     <= '0;
`ifdef MOTION_TIMEOUT_EN
      r_motion    <= '0;
`endif
    end else begin
      r_btn_d1    <= push_btn;
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      motor_open  <= (w_state_nxt == S_OPENING);
      motor_close <= (w_state_nxt == S_CLOSING);
      door_open   <= (w_state_nxt == S_OPEN);
      fault       <= TIMEOUT_EN && (w_state_nxt == S_FAULT);
      if (r_state == S_CLOSING && w_reverse && rev_cnt != '1)
        rev_cnt <= rev_cnt + 8'd1;
`ifdef MOTION_TIMEOUT_EN
      // counter is zero on the first cycle of each motion state
      if (w_state_nxt != r_state)
        r_motion <= '0;
      else if (r_state == S_OPENING || r_state == S_CLOSING)
        r_motion <= r_motion + CNT_W'(1);
`endif
    end
  end

endmodule
